// File: rtl/calc_accum_sseg.sv
// calc_accum_sseg: WIDTH-bit add/sub accumulator with a sticky overflow flag,
// driving a time-multiplexed DIGITS-wide active-low seven-segment display.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   operand, op_valid     operand and single-cycle apply strobe
//   sub, signed_mode      operation select / two's complement vs unsigned
//   clear                 synchronous clear of accumulator and overflow
//   result, overflow      accumulator value, sticky invalid-result flag
//   neg                   signed_mode & result msb (combinational)
//   sseg, an              segments (sseg[0]=a..sseg[6]=g) and anodes, active-low
module calc_accum_sseg #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  operand,
   input  logic              op_valid,
   input  logic              sub,
   input  logic              signed_mode,
   input  logic              clear,
   output logic [WIDTH-1:0]  result,
   output logic              overflow,
   output logic              neg,
   output logic [6:0]        sseg,
   output logic [DIGITS-1:0] an
);

   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [6:0]  SEG_BLANK = 7'h7F;
   localparam logic [6:0]  SEG_MINUS = 7'b0111111;

   logic [WIDTH-1:0]  acc_q,  acc_d;
   logic              ovf_q,  ovf_d;
   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic [IDX_W-1:0]  idx_q,  idx_d;
   logic [DIGITS-1:0] an_q,   an_d;
   logic [6:0]        sseg_q, sseg_d;

   logic [WIDTH:0]    add_ext;
   logic [WIDTH-1:0]  diff;
   logic              op_ovf;
   logic              neg_d;
   logic [WIDTH-1:0]  mag;
   logic [3:0]        nib;

   // Hex digit to active-low segment pattern (gfedcba).
   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Arithmetic and per-operation overflow in the current mode.
   always_comb begin
      add_ext = {1'b0, acc_q} + {1'b0, operand};
      diff    = acc_q - operand;
      op_ovf  = 1'b0;
      if (signed_mode) begin
         if (sub) op_ovf = (acc_q[WIDTH-1] == ~operand[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
         else     op_ovf = (acc_q[WIDTH-1] == operand[WIDTH-1]) && (add_ext[WIDTH-1] != acc_q[WIDTH-1]);
      end else begin
         if (sub) op_ovf = (operand > acc_q);
         else     op_ovf = add_ext[WIDTH];
      end
   end

   // Accumulator and sticky overflow; clear wins over op_valid.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (clear) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (op_valid) begin
         acc_d = sub ? diff : add_ext[WIDTH-1:0];
         ovf_d = ovf_q | op_ovf;
      end
   end

   // Scan counter and digit index.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Display content is built from next-state values so that an and sseg
   // always reflect the accumulator and index held in the registers together.
   always_comb begin
      neg_d  = signed_mode & acc_d[WIDTH-1];
      mag    = neg_d ? (~acc_d + WIDTH'(1)) : acc_d;
      nib    = 4'(mag >> {idx_d, 2'b00});
      sseg_d = SEG_BLANK;
      if (32'(idx_d) < NIBBLES)               sseg_d = hex_seg(nib);
      else if (idx_d == IDX_W'(DIGITS - 1))   sseg_d = neg_d ? SEG_MINUS : SEG_BLANK;
      an_d = ~(DIGITS'(1) << idx_d);
      if (ovf_d) an_d = '1;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
         idx_q  <= '0;
         an_q   <= '1;
         sseg_q <= SEG_BLANK;
      end else begin
         acc_q  <= acc_d;
         ovf_q  <= ovf_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         an_q   <= an_d;
         sseg_q <= sseg_d;
      end
   end

   assign result   = acc_q;
   assign overflow = ovf_q;
   assign neg      = signed_mode & acc_q[WIDTH-1];
   assign sseg     = sseg_q;
   assign an       = an_q;

endmodule

// File: tb/tb_calc_accum_sseg.sv
// Bench for calc_accum_sseg with WIDTH=8, DIGITS=4, SCAN_DIV=4.
module tb_calc_accum_sseg;

   logic       clk;
   logic       rst_n;
   logic [7:0] operand;
   logic       op_valid;
   logic       sub;
   logic       signed_mode;
   logic       clear;
   logic [7:0] result;
   logic       overflow;
   logic       neg;
   logic [6:0] sseg;
   logic [3:0] an;

   calc_accum_sseg #(.WIDTH(8), .DIGITS(4), .SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .operand(operand), .op_valid(op_valid),
      .sub(sub), .signed_mode(signed_mode), .clear(clear),
      .result(result), .overflow(overflow), .neg(neg), .sseg(sseg), .an(an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       opv;
      logic       sb;
      logic       sm;
      logic [7:0] opnd;
      logic [7:0] e_res;
      logic       e_ovf;
      logic       e_neg;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic       ovf;
      logic       ng;
   } exp_t;

   localparam int NVEC = 27;
   vec_t vecs [NVEC];
   exp_t sb_q [$];

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SF = 7'b0001110;
   localparam logic [6:0] SB = 7'h7F;
   localparam logic [6:0] SM = 7'b0111111;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic v, input logic s, input logic m, input logic [7:0] o);
      @(negedge clk);
      clear = c; op_valid = v; sub = s; signed_mode = m; operand = o;
   endtask

   // Wait (bounded) until digit k is lit, then compare its segments.
   task automatic wait_digit(input int k, input logic [6:0] exp, input string nm);
      logic [3:0] want;
      logic       found;
      want  = ~(4'b0001 << k);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(posedge clk); #1;
         if (an == want) found = 1'b1;
      end
      if (found) check(nm, 32'(sseg), 32'(exp));
      else begin
         checks++; errors++;
         $display("FAIL %s: timeout waiting for an=%b", nm, want);
      end
   endtask

   function automatic vec_t mk(input logic c, input logic v, input logic s, input logic m,
                               input logic [7:0] o, input logic [7:0] r, input logic f, input logic n);
      vec_t t;
      t.clr = c; t.opv = v; t.sb = s; t.sm = m; t.opnd = o;
      t.e_res = r; t.e_ovf = f; t.e_neg = n;
      return t;
   endfunction

   initial begin
      exp_t       e;
      logic [3:0] exp_an;
      int         idx;
      int         dark_bad;

      //            clr opv sub sm  opnd   res    ovf neg
      vecs[0]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      vecs[1]  = mk(0, 1, 0, 0, 8'd200, 8'hC8, 0, 0);
      vecs[2]  = mk(0, 1, 0, 0, 8'd100, 8'h2C, 1, 0);
      vecs[3]  = mk(0, 0, 0, 0, 8'h00, 8'h2C, 1, 0);
      vecs[4]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      vecs[5]  = mk(0, 1, 0, 1, 8'd5,   8'h05, 0, 0);
      vecs[6]  = mk(0, 1, 1, 1, 8'd12,  8'hF9, 0, 1);
      vecs[7]  = mk(0, 0, 0, 0, 8'h00, 8'hF9, 0, 0);
      vecs[8]  = mk(1, 0, 0, 1, 8'h00, 8'h00, 0, 0);
      vecs[9]  = mk(0, 1, 0, 1, 8'd100, 8'h64, 0, 0);
      vecs[10] = mk(0, 1, 0, 1, 8'd100, 8'hC8, 1, 1);
      vecs[11] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      vecs[12] = mk(0, 1, 0, 0, 8'd100, 8'h64, 0, 0);
      vecs[13] = mk(0, 1, 0, 0, 8'd100, 8'hC8, 0, 0);
      vecs[14] = mk(1, 0, 0, 1, 8'h00, 8'h00, 0, 0);
      vecs[15] = mk(0, 1, 0, 1, 8'h80, 8'h80, 0, 1);
      vecs[16] = mk(0, 1, 1, 1, 8'h01, 8'h7F, 1, 0);
      vecs[17] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      vecs[18] = mk(0, 1, 0, 0, 8'h33, 8'h33, 0, 0);
      vecs[19] = mk(1, 1, 0, 0, 8'h07, 8'h00, 0, 0);
      vecs[20] = mk(0, 1, 1, 0, 8'h01, 8'hFF, 1, 0);
      vecs[21] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      vecs[22] = mk(0, 1, 0, 0, 8'hFF, 8'hFF, 0, 0);
      vecs[23] = mk(0, 1, 0, 0, 8'h01, 8'h00, 1, 0);
      vecs[24] = mk(1, 0, 0, 1, 8'h00, 8'h00, 0, 0);
      vecs[25] = mk(0, 1, 1, 1, 8'h80, 8'h80, 1, 1);
      vecs[26] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);

      rst_n = 1'b0; clear = 1'b0; op_valid = 1'b0; sub = 1'b0;
      signed_mode = 1'b0; operand = '0;

      // Reset state while held
      #12;
      check("rst_an", 32'(an), 32'hF);
      check("rst_sseg", 32'(sseg), 32'h7F);
      check("rst_result", 32'(result), 32'h0);
      check("rst_ovf", 32'(overflow), 32'h0);
      check("rst_neg", 32'(neg), 32'h0);

      // Scan walk after release: after n edges, index = (n/4)%4
      @(negedge clk); rst_n = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk); #1;
         idx    = (n / 4) % 4;
         exp_an = ~(4'b0001 << idx);
         check($sformatf("walk_an_%0d", n), 32'(an), 32'(exp_an));
         check($sformatf("walk_sseg_%0d", n), 32'(sseg), (idx < 2) ? 32'(S0) : 32'(SB));
      end

      // Table-driven operations through the scoreboard
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].clr, vecs[i].opv, vecs[i].sb, vecs[i].sm, vecs[i].opnd);
         e.res = vecs[i].e_res; e.ovf = vecs[i].e_ovf; e.ng = vecs[i].e_neg;
         sb_q.push_back(e);
         @(posedge clk); #1;
         e = sb_q.pop_front();
         check($sformatf("vec%0d_result", i), 32'(result), 32'(e.res));
         check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(e.ovf));
         check($sformatf("vec%0d_neg", i), 32'(neg), 32'(e.ng));
      end
      drive(0, 0, 0, 0, 8'h00);

      // Signed -7 display, then unsigned F9 view
      drive(1, 0, 0, 1, 8'h00);
      drive(0, 1, 0, 1, 8'd5);
      drive(0, 1, 1, 1, 8'd12);
      drive(0, 0, 0, 1, 8'h00);
      wait_digit(0, S7, "neg_d0");
      wait_digit(1, S0, "neg_d1");
      wait_digit(2, SB, "neg_d2");
      wait_digit(3, SM, "neg_d3");
      check("neg_flag", 32'(neg), 32'h1);
      drive(0, 0, 0, 0, 8'h00);
      @(posedge clk); #1;
      check("uns_neg", 32'(neg), 32'h0);
      check("uns_result", 32'(result), 32'hF9);
      wait_digit(0, S9, "uns_d0");
      wait_digit(1, SF, "uns_d1");
      wait_digit(3, SB, "uns_d3");
      check("uns_ovf", 32'(overflow), 32'h0);

      // Unsigned overflow darkens display; clear resumes scan
      drive(1, 0, 0, 0, 8'h00);
      drive(0, 1, 0, 0, 8'd200);
      drive(0, 1, 0, 0, 8'd100);
      @(posedge clk); #1;
      check("dark_ovf", 32'(overflow), 32'h1);
      check("dark_an0", 32'(an), 32'hF);
      drive(0, 0, 0, 0, 8'h00);
      dark_bad = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (an !== 4'hF) dark_bad++;
      end
      check("dark_hold_count", 32'(dark_bad), 32'h0);
      drive(1, 0, 0, 0, 8'h00);
      drive(0, 0, 0, 0, 8'h00);
      wait_digit(0, S0, "resume_d0");
      check("resume_ovf", 32'(overflow), 32'h0);

      // Async reset mid-scan at digit 2
      drive(0, 1, 0, 0, 8'h33);
      drive(0, 0, 0, 0, 8'h00);
      wait_digit(2, SB, "pre_rst_d2");
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_an", 32'(an), 32'hF);
      check("midrst_result", 32'(result), 32'h0);
      check("midrst_sseg", 32'(sseg), 32'h7F);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("restart_an", 32'(an), 32'hE);
      check("restart_sseg", 32'(sseg), 32'(S0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_accum_sseg.md
Name: calc_accum_sseg

Overview:
Parametrised successor to the lab combinational 4-bit add/sub calculator. Holds a WIDTH-bit accumulator that is added to or subtracted from on each operand strobe, in signed or unsigned mode, with a sticky overflow flag. Drives a time-multiplexed DIGITS-wide seven-segment display: hex magnitude, a sign digit, and all digits blanked on invalid results. Sits between board switches/debounced buttons and the Basys-style display.

Parameters:
WIDTH, 8, accumulator/operand width in bits; multiple of 4, 4..16
DIGITS, 4, number of display digits; must satisfy DIGITS >= WIDTH/4 + 1
SCAN_DIV, 100000, clk cycles each digit stays lit; >= 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
operand  in  WIDTH  value applied on op_valid
op_valid  in  1  single-cycle strobe: apply operation
sub  in  1  1 = acc - operand, 0 = acc + operand; sampled with op_valid
signed_mode  in  1  1 = two's complement, 0 = unsigned (the RC mode)
clear  in  1  synchronous clear of accumulator and overflow
result  out  WIDTH  accumulator value
overflow  out  1  sticky invalid-result flag
neg  out  1  signed_mode & result[WIDTH-1]
sseg  out  7  segments, active-low; sseg[0]=a .. sseg[6]=g
an  out  DIGITS  anodes, active-low, one-hot-low while scanning

Behaviour:
- Reset (rst_n=0, async): result=0, overflow=0, scan counter=0, digit index=0. While reset is held: an = all ones, sseg = 7'h7F.
- clear=1 at a clk edge: result=0, overflow=0. clear has priority over op_valid in the same cycle. Scan is unaffected.
- op_valid=1 and clear=0: the next edge loads result <= result ± operand, truncated to WIDTH. Latency is 1 cycle. One operation per asserted cycle; back-to-back strobes chain.
- Overflow is evaluated on each operation in the current mode:
  - Unsigned add: carry out = 1.
  - Unsigned sub: borrow, i.e. operand > result.
  - Signed: operands' effective sign bits agree and the sum's sign differs. For sub, use the inverted operand sign.
  - The flag is ORed into overflow and sticky until clear or reset.
- Toggling signed_mode does not alter result or overflow. It changes only neg and the displayed magnitude, combinationally.
- Magnitude: if neg, mag = (~result + 1) mod 2^WIDTH, else mag = result. The most negative value displays as 2^(WIDTH-1), e.g. "80" for WIDTH=8.
- Display scan:
  - Counter counts 0..SCAN_DIV-1. At the wrap, digit index increments, and wraps from DIGITS-1 to 0.
  - an[k] = 0 only for k = index, registered.
  - Digit k < WIDTH/4 shows hex nibble mag[4k+3:4k] with the standard 0-F pattern.
  - Digit DIGITS-1 shows '-' (7'b0111111) if neg, else blank (7'h7F).
  - Other digits are blank.
- Invalid: while overflow=1, an = all ones (display dark). The scan counter keeps running and sseg content is don't-care.
- sseg and an change on the same edge: no ghost digit.
- 0 hex pattern 7'b1000000. Blank 7'h7F.

Test Plan:
(WIDTH=8, DIGITS=4, SCAN_DIV=4)
- Reset release, no ops -> result=0, overflow=0, neg=0. an walks 1110,1101,1011,0111 every 4 cycles. Digits 0,1 show 7'b1000000; digits 2,3 blank.
- signed_mode=0: op add 200, then add 100 -> result=8'h2C, overflow=1 one cycle after the second strobe, an=1111 thereafter; clear -> overflow=0, scan resumes.
- signed_mode=1: add 5, then sub 12 -> result=8'hF9, neg=1. Digit0='7', digit1='0', digit2 blank, digit3='-'. Switch signed_mode=0 -> neg=0, display "F9", overflow stays 0.
- signed_mode=1: add 100 twice -> result=8'hC8, overflow=1. Repeat with signed_mode=0 -> overflow=0. signed_mode=1: sub 1 from 8'h80 -> overflow=1.
- clear and op_valid (add 7) in the same cycle with result=8'h33 -> result=0, overflow=0.
- Assert rst_n=0 mid-scan (index=2) between edges -> an=1111 and result=0 immediately. After release, scan restarts at digit 0.
